// File: rtl/sprite_plotter.sv
// sprite_plotter: generic SPR_W x SPR_H sprite blitter.
//
// Reads a sprite from an external synchronous ROM (one-cycle read latency),
// offsets every pixel by a latched screen origin, and drives the VGA adapter
// pixel port. It supports:
// - transparent-colour skipping;
// - clipping of pixels that fall outside SCREEN_W x SCREEN_H;
// - an erase mode that paints the visible footprint with BG_COLOUR.
//
// Optional feature: define SPRITE_MIRROR_EN to add a 'mirror' input, latched
// with start, that flips the sprite horizontally.
//
// Ports:
//   clk, reset          system clock, asynchronous active-high reset
//   start               draw request, sampled only while idle
//   erase               latched with start; 1 = paint footprint with BG_COLOUR
//   x_origin, y_origin  sprite top-left corner, latched with start
//   mirror              (SPRITE_MIRROR_EN only) latched with start; 1 = flip
//   rom_addr            sprite ROM address, row*SPR_W + col
//   rom_data            ROM colour, valid one cycle after rom_addr
//   x, y, colour, plot  VGA pixel write port
//   busy                high whenever a draw is in progress
//   done                one-cycle pulse after the last pixel slot
module sprite_plotter #(
    parameter int SPR_W    = 28,
    parameter int SPR_H    = 20,
    parameter int X_W      = 9,
    parameter int Y_W      = 8,
    parameter int COL_W    = 3,
    parameter int ADDR_W   = 10,
    parameter int SCREEN_W = 320,
    parameter int SCREEN_H = 240,
    parameter logic [COL_W-1:0] TRANSPARENT = '0,
    parameter logic [COL_W-1:0] BG_COLOUR   = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              erase,
    input  logic [X_W-1:0]    x_origin,
    input  logic [Y_W-1:0]    y_origin,
`ifdef SPRITE_MIRROR_EN
    input  logic              mirror,
`endif
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [COL_W-1:0]  rom_data,
    output logic [X_W-1:0]    x,
    output logic [Y_W-1:0]    y,
    output logic [COL_W-1:0]  colour,
    output logic              plot,
    output logic              busy,
    output logic              done
);

    localparam int CW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam int RW = (SPR_H > 1) ? $clog2(SPR_H) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(SPR_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(SPR_H - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       col_q, col_d;
    logic [RW-1:0]       row_q, row_d;
    logic [ADDR_W-1:0]   row_base_q, row_base_d;
    logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
    logic [X_W-1:0]      x_org_q, x_org_d;
    logic [Y_W-1:0]      y_org_q, y_org_d;
    logic                erase_q, erase_d;
    logic                mirror_q, mirror_d;
    logic                issue;

    logic [CW-1:0]       col_p1_q, col_p1_d;
    logic [RW-1:0]       row_p1_q, row_p1_d;
    logic                vld_p1_q, vld_p1_d;

    logic [X_W:0]        xf_p2;
    logic [Y_W:0]        yf_p2;
    logic [X_W-1:0]      x_q, x_d;
    logic [Y_W-1:0]      y_q, y_d;
    logic [COL_W-1:0]    colour_q, colour_d;
    logic                plot_q, plot_d;
    logic                done_q, done_d;

    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        row_d      = row_q;
        row_base_d = row_base_q;
        rom_addr_d = rom_addr_q;
        x_org_d    = x_org_q;
        y_org_d    = y_org_q;
        erase_d    = erase_q;
        mirror_d   = mirror_q;
        issue      = 1'b0;

        // Address generation: one ROM address per RUN cycle
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_RUN;
                    x_org_d    = x_origin;
                    y_org_d    = y_origin;
                    erase_d    = erase;
`ifdef SPRITE_MIRROR_EN
                    mirror_d   = mirror;
`endif
                    col_d      = '0;
                    row_d      = '0;
                    row_base_d = '0;
                    issue      = 1'b1;
                end
            end
            S_RUN: begin
                if (col_q == COL_LAST) begin
                    if (row_q == ROW_LAST) begin
                        state_d = S_DRAIN;
                    end else begin
                        col_d      = '0;
                        row_d      = row_q + RW'(1);
                        row_base_d = row_base_q + ADDR_W'(SPR_W);
                        issue      = 1'b1;
                    end
                end else begin
                    col_d = col_q + CW'(1);
                    issue = 1'b1;
                end
            end
            S_DRAIN: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Mirroring only changes which ROM column is fetched; x still follows col.
        if (issue) begin
            if (mirror_d) begin
                rom_addr_d = row_base_d + ADDR_W'(COL_LAST - col_d);
            end else begin
                rom_addr_d = row_base_d + ADDR_W'(col_d);
            end
        end

        // Stage p1: delay col/row one cycle to line up with rom_data
        col_p1_d = col_q;
        row_p1_d = row_q;
        vld_p1_d = (state_q == S_RUN);

        // Stage p2: screen position, clipping, transparency, colour select
        xf_p2    = (X_W+1)'(x_org_q) + (X_W+1)'(col_p1_q);
        yf_p2    = (Y_W+1)'(y_org_q) + (Y_W+1)'(row_p1_q);
        plot_d   = vld_p1_q
                   && (xf_p2 < (X_W+1)'(SCREEN_W))
                   && (yf_p2 < (Y_W+1)'(SCREEN_H))
                   && (erase_q || (rom_data != TRANSPARENT));
        x_d      = x_q;
        y_d      = y_q;
        colour_d = colour_q;
        if (plot_d) begin
            x_d      = xf_p2[X_W-1:0];
            y_d      = yf_p2[Y_W-1:0];
            colour_d = erase_q ? BG_COLOUR : rom_data;
        end

        // done is registered off the DONE state, so it follows the last pixel slot
        done_d = (state_q == S_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            col_q      <= '0;
            row_q      <= '0;
            row_base_q <= '0;
            rom_addr_q <= '0;
            x_org_q    <= '0;
            y_org_q    <= '0;
            erase_q    <= 1'b0;
            mirror_q   <= 1'b0;
            col_p1_q   <= '0;
            row_p1_q   <= '0;
            vld_p1_q   <= 1'b0;
            x_q        <= '0;
            y_q        <= '0;
            colour_q   <= '0;
            plot_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            row_q      <= row_d;
            row_base_q <= row_base_d;
            rom_addr_q <= rom_addr_d;
            x_org_q    <= x_org_d;
            y_org_q    <= y_org_d;
            erase_q    <= erase_d;
            mirror_q   <= mirror_d;
            col_p1_q   <= col_p1_d;
            row_p1_q   <= row_p1_d;
            vld_p1_q   <= vld_p1_d;
            x_q        <= x_d;
            y_q        <= y_d;
            colour_q   <= colour_d;
            plot_q     <= plot_d;
            done_q     <= done_d;
        end
    end

    assign rom_addr = rom_addr_q;
    assign x        = x_q;
    assign y        = y_q;
    assign colour   = colour_q;
    assign plot     = plot_q;
    assign done     = done_q;
    assign busy     = (state_q != S_IDLE);

endmodule
